pin_lock_ctrl: RTL
==================

PIN_LOCK_CTRL -- requirements
Module: pin_lock_ctrl

Interface
REQ-001 SHALL provide parameter UNLOCK_CYCLES, default 8: number of cycles unlocked stays high after a correct PIN.
REQ-002 SHALL provide parameter LOCKOUT_CYCLES, default 16: number of cycles locked_out stays high.
REQ-003 SHALL provide parameter MAX_FAILS, default 3: consecutive failed attempts that trigger lockout; legal range 1..3.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enter, input, 1 bit: one-cycle pulse, one digit presented.
REQ-007 SHALL have port correct_digit, input, 1 bit: per-digit match from the digit checker, valid in the same cycle as enter.
REQ-008 SHALL have port clear, input, 1 bit: abort the current entry.
REQ-009 SHALL have port digit_idx, output, 2 bits: current digit position 0..3; drives the checker's state input.
REQ-010 SHALL have port unlocked, output, 1 bit: access granted.
REQ-011 SHALL have port fail, output, 1 bit: one-cycle pulse when an attempt is rejected.
REQ-012 SHALL have port locked_out, output, 1 bit: entry disabled after repeated failures.
REQ-013 SHALL have port attempts, output, 2 bits: consecutive failed-attempt count, saturating at 3.

Function
REQ-014 SHALL implement the FSM states ENTRY, UNLOCK, FAIL and LOCKOUT, all registered.
REQ-015 In ENTRY, each enter SHALL OR !correct_digit into an internal mismatch flag and increment digit_idx.
REQ-016 The enter that arrives with digit_idx=3 SHALL end the attempt:
- mismatch clear (including the current digit) -> UNLOCK;
- otherwise -> FAIL.
- digit_idx returns to 0 in both cases.
REQ-017 All 4 digits SHALL always be collected before any verdict; no early rejection.
REQ-018 UNLOCK:
- unlocked=1 for exactly UNLOCK_CYCLES cycles, starting the cycle after the deciding enter edge;
- attempts cleared on entry;
- then ENTRY.
REQ-019 FAIL SHALL last exactly one cycle with fail=1 and attempts incremented with saturation at 3.
REQ-020 From FAIL, the next state SHALL be LOCKOUT if the post-increment attempts >= MAX_FAILS and lockout is compiled in; otherwise ENTRY.
REQ-021 LOCKOUT:
- locked_out=1 for exactly LOCKOUT_CYCLES cycles;
- then ENTRY with attempts cleared.
REQ-022 enter and clear SHALL be ignored in UNLOCK, FAIL and LOCKOUT; digit_idx holds at 0 in those states.
REQ-023 clear in ENTRY SHALL set digit_idx=0 and clear mismatch, without counting a failure.
REQ-024 When clear and enter coincide, clear SHALL win.
REQ-025 Dwell counters SHALL be wide enough for their parameter and SHALL not wrap early; all outputs SHALL be registered.

Reset
REQ-026 rst SHALL force ENTRY, digit_idx=0, mismatch=0, attempts=0, unlocked=0, fail=0, locked_out=0 and dwell counters=0 on the next edge.
REQ-027 rst SHALL take priority over all inputs.
REQ-028 rst asserted mid-UNLOCK or mid-LOCKOUT SHALL terminate that state immediately.

Configuration
REQ-029 Macro LOCKOUT_EN defined: the LOCKOUT state and REQ-020/021 behaviour SHALL be present.
REQ-030 Macro LOCKOUT_EN undefined:
- locked_out SHALL be tied 0;
- FAIL SHALL always return to ENTRY;
- attempts SHALL still count and saturate at 3, cleared only by UNLOCK or rst.

Verification (checker PIN 9,9,7,9 modelled in bench)
REQ-031 Enters 9,9,7,9 -> unlocked=1 for 8 cycles starting the cycle after the 4th enter, fail never asserted, attempts=0.
REQ-032 Enters 9,9,8,9 -> fail=1 for one cycle after the 4th enter, attempts=1, digit_idx=0, unlocked stays 0.
REQ-033 Three wrong attempts with LOCKOUT_EN -> locked_out=1 for 16 cycles, enters ignored throughout, then attempts=0 and a correct PIN unlocks.
REQ-034 Enters 9,9 then clear (also clear coincident with enter) -> digit_idx=0, no fail; a following 9,9,7,9 unlocks.
REQ-035 rst pulsed on cycle 3 of UNLOCK and of LOCKOUT -> all outputs 0 and state ENTRY on the next cycle.
REQ-036 Without LOCKOUT_EN, four wrong attempts -> four fail pulses, attempts saturates at 3, locked_out remains 0.

Source files
------------

// File: rtl/pin_lock_ctrl.sv
// ============================================================================
// Module   : pin_lock_ctrl
// Brief    : 4-digit PIN entry sequencer with unlock dwell, fail pulse and
//            optional lockout after repeated failures (macro LOCKOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pin_lock_ctrl #(
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int MAX_FAILS      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       correct_digit,
  input  logic       clear,
  output logic [1:0] digit_idx,
  output logic       unlocked,
  output logic       fail,
  output logic       locked_out,
  output logic [1:0] attempts
);

`ifdef LOCKOUT_EN
  localparam bit LOCKOUT_ON = 1'b1;
`else
  localparam bit LOCKOUT_ON = 1'b0;
`endif

  // The dwell counter counts down from N-1, so it only needs to hold N-1.
  localparam int CNT_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] UNLOCK_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]       FAIL_LIMIT   = 2'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_UNLOCK  = 2'd1,
    ST_FAIL    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             mismatch_q, mismatch_d;
  logic [1:0]       attempts_q, attempts_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unlocked_q, unlocked_d;
  logic             fail_q, fail_d;
  logic             locked_out_q, locked_out_d;
  logic [1:0]       attempts_inc;

  assign attempts_inc = (attempts_q == 2'd3) ? 2'd3 : attempts_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mismatch_d   = mismatch_q;
    attempts_d   = attempts_q;
    cnt_d        = cnt_q;
    unlocked_d   = 1'b0;
    fail_d       = 1'b0;
    locked_out_d = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (clear) begin
          idx_d      = 2'd0;
          mismatch_d = 1'b0;
        end else if (enter) begin
          if (idx_q == 2'd3) begin
            idx_d      = 2'd0;
            mismatch_d = 1'b0;
            // Verdict includes the digit arriving with this final enter.
            if (mismatch_q || !correct_digit) begin
              state_d    = ST_FAIL;
              fail_d     = 1'b1;
              attempts_d = attempts_inc;
            end else begin
              state_d    = ST_UNLOCK;
              unlocked_d = 1'b1;
              attempts_d = 2'd0;
              cnt_d      = UNLOCK_LOAD;
            end
          end else begin
            idx_d      = idx_q + 2'd1;
            mismatch_d = mismatch_q | ~correct_digit;
          end
        end
      end

      ST_UNLOCK: begin
        idx_d = 2'd0;
        if (cnt_q == '0) begin
          state_d = ST_ENTRY;
        end else begin
          cnt_d      = cnt_q - 1'b1;
          unlocked_d = 1'b1;
        end
      end

      ST_FAIL: begin
        idx_d = 2'd0;
        if (LOCKOUT_ON && (attempts_q >= FAIL_LIMIT)) begin
          state_d      = ST_LOCKOUT;
          locked_out_d = 1'b1;
          cnt_d        = LOCKOUT_LOAD;
        end else begin
          state_d = ST_ENTRY;
        end
      end

      ST_LOCKOUT: begin
        idx_d = 2'd0;
        if (cnt_q == '0) begin
          state_d    = ST_ENTRY;
          attempts_d = 2'd0;
        end else begin
          cnt_d        = cnt_q - 1'b1;
          locked_out_d = LOCKOUT_ON;
        end
      end

      default: begin
        state_d = ST_ENTRY;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ENTRY;
      idx_q        <= 2'd0;
      mismatch_q   <= 1'b0;
      attempts_q   <= 2'd0;
      cnt_q        <= '0;
      unlocked_q   <= 1'b0;
      fail_q       <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mismatch_q   <= mismatch_d;
      attempts_q   <= attempts_d;
      cnt_q        <= cnt_d;
      unlocked_q   <= unlocked_d;
      fail_q       <= fail_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign digit_idx  = idx_q;
  assign unlocked   = unlocked_q;
  assign fail       = fail_q;
  assign locked_out = locked_out_q;
  assign attempts   = attempts_q;

endmodule

`default_nettype wire
